// File: rtl/lsu_pkg.sv
// Shared state encoding and RV32I load/store width codes for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_if.sv
// Core request/response channel plus word-wide memory port of the load/store unit.
interface lsu_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [3:0]  data_write_byte;
  logic        data_read_valid;
  logic        data_write_valid;
  logic [31:0] data_read;

  // The master is the environment (core plus memory); the slave is the unit.
  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, data_read,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
    input  data_addr, data_write, data_write_byte, data_read_valid, data_write_valid
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, data_read,
    output req_ready, resp_valid, resp_rdata, resp_fault,
    output data_addr, data_write, data_write_byte, data_read_valid, data_write_valid
  );

endinterface

// File: rtl/lsu_align.sv
// Width/offset decode: fault detection, byte enables, store replication and load extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        fault,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [3:0][7:0] lane;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [31:0]     sel_word;

  // Memory returns byte base+k in the k-th most significant lane.
  assign lane     = {rdata_raw[7:0], rdata_raw[15:8], rdata_raw[23:16], rdata_raw[31:24]};
  assign sel_byte = lane[offset];
  assign sel_half = {lane[{offset[1], 1'b1}], lane[{offset[1], 1'b0}]};
  assign sel_word = {lane[3], lane[2], lane[1], lane[0]};

  always_comb begin
    fault     = 1'b1;
    byte_en   = 4'b0000;
    wdata_rep = '0;
    load_data = '0;
    case (funct3)
      F3_B, F3_BU: begin
        fault     = store && (funct3 == F3_BU);
        byte_en   = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        load_data = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'd0, sel_byte};
      end
      F3_H, F3_HU: begin
        fault     = offset[0] || (store && (funct3 == F3_HU));
        byte_en   = 4'b0011 << offset;
        wdata_rep = {2{wdata[15:0]}};
        load_data = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'd0, sel_half};
      end
      F3_W: begin
        fault     = |offset;
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        load_data = sel_word;
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: latches a request, performs one
// word-aligned memory access and holds the extended response until taken.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_WAIT = 1
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);

  lsu_state_t  state, next_state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        fault_q;
  logic [3:0]  cnt;

  logic        idle, accept, last_read;
  logic        al_store;
  logic [2:0]  al_funct3;
  logic [1:0]  al_offset;
  logic [31:0] al_wdata;
  logic        al_fault;
  logic [3:0]  al_byte_en;
  logic [31:0] al_wdata_rep;
  logic [31:0] al_load;

  assign idle      = (state == IDLE);
  assign accept    = idle && bus.req_valid;
  assign last_read = (state == READ) && (cnt == 4'(READ_WAIT - 1));

  // While idle the aligner looks at the live request so the fault is known at accept.
  assign al_store  = idle ? bus.req_store      : store_q;
  assign al_funct3 = idle ? bus.req_funct3     : funct3_q;
  assign al_offset = idle ? bus.req_addr[1:0]  : addr_q[1:0];
  assign al_wdata  = idle ? bus.req_wdata      : wdata_q;

  lsu_align u_align (
    .store     (al_store),
    .funct3    (al_funct3),
    .offset    (al_offset),
    .wdata     (al_wdata),
    .rdata_raw (bus.data_read),
    .fault     (al_fault),
    .byte_en   (al_byte_en),
    .wdata_rep (al_wdata_rep),
    .load_data (al_load)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      fault_q  <= 1'b0;
      cnt      <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        store_q  <= bus.req_store;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        fault_q  <= al_fault;
        rdata_q  <= '0;
        cnt      <= '0;
      end else if (state == READ) begin
        cnt <= cnt + 4'd1;
        if (last_read) rdata_q <= al_load;
      end
    end
  end

  always_comb begin
    next_state           = state;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_rdata       = '0;
    bus.resp_fault       = 1'b0;
    bus.data_read_valid  = 1'b0;
    bus.data_write_valid = 1'b0;
    bus.data_write_byte  = 4'b0000;
    bus.data_write       = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) next_state = al_fault ? RESP : (bus.req_store ? WRITE : READ);
      end
      WRITE: begin
        bus.data_write_valid = 1'b1;
        bus.data_write_byte  = al_byte_en;
        bus.data_write       = al_wdata_rep;
        next_state           = RESP;
      end
      READ: begin
        bus.data_read_valid = 1'b1;
        if (last_read) next_state = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = rdata_q;
        bus.resp_fault = fault_q;
        if (bus.resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.data_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-level memory model, per-cycle compare
// against expected strobes/responses, and literal anchors for the model itself.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_if bus1 ();
  lsu_if bus3 ();

  load_store_unit #(.READ_WAIT(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  load_store_unit #(.READ_WAIT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  int vec_count = 0;
  int miss_count = 0;

  logic        use3 = 1'b0;
  logic        drv_valid = 1'b0;
  logic        drv_store = 1'b0;
  logic [2:0]  drv_f3 = 3'b000;
  logic [31:0] drv_addr = '0;
  logic [31:0] drv_wdata = '0;
  logic        drv_rready = 1'b1;

  assign bus1.req_valid  = drv_valid & ~use3;
  assign bus3.req_valid  = drv_valid & use3;
  assign bus1.req_store  = drv_store;
  assign bus3.req_store  = drv_store;
  assign bus1.req_funct3 = drv_f3;
  assign bus3.req_funct3 = drv_f3;
  assign bus1.req_addr   = drv_addr;
  assign bus3.req_addr   = drv_addr;
  assign bus1.req_wdata  = drv_wdata;
  assign bus3.req_wdata  = drv_wdata;
  assign bus1.resp_ready = drv_rready;
  assign bus3.resp_ready = drv_rready;

  logic        s_req_ready, s_rv, s_wv, s_resp_valid, s_fault;
  logic [3:0]  s_be;
  logic [31:0] s_wd, s_addr, s_rdata;

  assign s_req_ready  = use3 ? bus3.req_ready        : bus1.req_ready;
  assign s_rv         = use3 ? bus3.data_read_valid  : bus1.data_read_valid;
  assign s_wv         = use3 ? bus3.data_write_valid : bus1.data_write_valid;
  assign s_resp_valid = use3 ? bus3.resp_valid       : bus1.resp_valid;
  assign s_fault      = use3 ? bus3.resp_fault       : bus1.resp_fault;
  assign s_be         = use3 ? bus3.data_write_byte  : bus1.data_write_byte;
  assign s_wd         = use3 ? bus3.data_write       : bus1.data_write;
  assign s_addr       = use3 ? bus3.data_addr        : bus1.data_addr;
  assign s_rdata      = use3 ? bus3.resp_rdata       : bus1.resp_rdata;

  // Memory seen by the DUTs; byte base+k is returned on the k-th most significant lane.
  logic [7:0] mem [64] = '{default: 8'h00};
  logic [5:0] a1, a3;
  assign a1 = bus1.data_addr[5:0];
  assign a3 = bus3.data_addr[5:0];
  always_comb bus1.data_read = {mem[a1], mem[a1 + 6'd1], mem[a1 + 6'd2], mem[a1 + 6'd3]};
  always_comb bus3.data_read = {mem[a3], mem[a3 + 6'd1], mem[a3 + 6'd2], mem[a3 + 6'd3]};

  always @(posedge clk) begin
    if (s_wv) begin
      for (int k = 0; k < 4; k++)
        if (s_be[k]) mem[s_addr[5:0] + 6'(k)] <= s_wd[8*k +: 8];
    end
  end

  // Reference byte memory updated only by the model.
  logic [7:0] model_mem [64] = '{default: 8'h00};

  function automatic void model_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] wd, output logic flt, output logic [31:0] rd,
                                       output logic [3:0] be, output logic [31:0] wrep);
    int size, off, base;
    logic [31:0] value;
    size = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    off  = int'(a[1:0]);
    base = int'(a[5:0]);
    flt  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || ((off % size) != 0) || (st && f3[2]);
    rd   = '0;
    be   = '0;
    wrep = '0;
    if (!flt) begin
      if (st) begin
        be = 4'(((1 << size) - 1) << off);
        for (int k = 0; k < 4; k++) wrep[8*k +: 8] = wd[8*(k % size) +: 8];
        for (int i = 0; i < size; i++) model_mem[base + i] = wd[8*i +: 8];
      end else begin
        value = '0;
        for (int i = 0; i < size; i++) value = value | (32'(model_mem[base + i]) << (8*i));
        if (!f3[2] && size < 4 && value[8*size-1]) value = value | (32'hFFFF_FFFF << (8*size));
        rd = value;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic        chk_en = 1'b0;
  logic        chk_addr = 1'b0;
  logic        exp_req_ready = 1'b1, exp_rv = 1'b0, exp_wv = 1'b0, exp_resp_valid = 1'b0, exp_fault = 1'b0;
  logic [3:0]  exp_be = '0;
  logic [31:0] exp_wd = '0, exp_rdata = '0, exp_addr = '0;

  task automatic expect_idle();
    exp_req_ready  = 1'b1;
    exp_rv         = 1'b0;
    exp_wv         = 1'b0;
    exp_resp_valid = 1'b0;
    exp_be         = '0;
    chk_addr       = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("req_ready", 32'(s_req_ready), 32'(exp_req_ready));
      checkOutput("read_strobe", 32'(s_rv), 32'(exp_rv));
      checkOutput("write_strobe", 32'(s_wv), 32'(exp_wv));
      checkOutput("byte_en", 32'(s_be), 32'(exp_be));
      checkOutput("resp_valid", 32'(s_resp_valid), 32'(exp_resp_valid));
      if (exp_wv) checkOutput("write_data", s_wd, exp_wd);
      if (chk_addr) checkOutput("data_addr", s_addr, exp_addr);
      if (exp_resp_valid) begin
        checkOutput("resp_rdata", s_rdata, exp_rdata);
        checkOutput("resp_fault", 32'(s_fault), 32'(exp_fault));
      end
    end
  end

  // Runs one request on the selected DUT; caller is just after a rising edge in IDLE.
  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input int hold,
                               output logic [31:0] got_rd, output logic got_flt,
                               output logic [3:0] got_be, output logic [31:0] got_wd,
                               output logic [31:0] got_addr);
    logic        flt;
    logic [31:0] rd, wrep;
    logic [3:0]  be;
    int          wait_n, t_resp;
    model_access(st, f3, a, wd, flt, rd, be, wrep);
    wait_n   = use3 ? 3 : 1;
    t_resp   = flt ? 1 : (st ? 2 : wait_n + 1);
    got_rd   = '0;
    got_flt  = 1'b0;
    got_be   = '0;
    got_wd   = '0;
    got_addr = '0;
    drv_valid = 1'b1;
    drv_store = st;
    drv_f3    = f3;
    drv_addr  = a;
    drv_wdata = wd;
    expect_idle();
    @(posedge clk); #1;
    // Busy-time request fields are junk that must neither be accepted nor leak into the response.
    drv_store = 1'b1;
    drv_f3    = F3_W;
    drv_addr  = 32'h0000_003C;
    drv_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= t_resp + hold; c++) begin
      exp_req_ready  = 1'b0;
      exp_rv         = !flt && !st && (c <= wait_n);
      exp_wv         = !flt && st && (c == 1);
      exp_be         = exp_wv ? be : 4'b0000;
      exp_wd         = wrep;
      exp_resp_valid = (c >= t_resp);
      exp_rdata      = rd;
      exp_fault      = flt;
      exp_addr       = a & 32'hFFFF_FFFC;
      chk_addr       = !flt;
      drv_rready     = (c == t_resp + hold);
      @(negedge clk);
      if (c == t_resp) begin
        got_rd  = s_rdata;
        got_flt = s_fault;
      end
      if (c == 1 && !flt) begin
        got_addr = s_addr;
        got_be   = s_be;
        got_wd   = s_wd;
      end
      @(posedge clk); #1;
    end
    drv_valid  = 1'b0;
    drv_rready = 1'b1;
    expect_idle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] g_rd, g_wd, g_addr;
  logic        g_flt;
  logic [3:0]  g_be;

  initial begin
    #12;
    checkOutput("rst_req_ready", 32'(bus1.req_ready), 32'd1);
    checkOutput("rst_req_ready3", 32'(bus3.req_ready), 32'd1);
    checkOutput("rst_strobes", {30'd0, bus1.data_read_valid, bus1.data_write_valid}, 32'd0);
    checkOutput("rst_resp_valid", 32'(bus1.resp_valid), 32'd0);
    checkOutput("rst_data_addr", bus1.data_addr, 32'd0);
    checkOutput("rst_byte_en", 32'(bus1.data_write_byte), 32'd0);
    checkOutput("rst_data_write", bus1.data_write, 32'd0);
    checkOutput("rst_rdata", bus1.resp_rdata, 32'd0);

    @(posedge clk); #1;
    reset  = 1'b1;
    expect_idle();
    chk_en = 1'b1;

    applyStimulus(1'b1, F3_B, 32'h5, 32'h1234_5678, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_sb_addr", g_addr, 32'h4);
    checkOutput("lit_sb_be", 32'(g_be), 32'h2);
    checkOutput("lit_sb_wdata", g_wd, 32'h7878_7878);
    checkOutput("lit_sb_fault", 32'(g_flt), 32'd0);

    applyStimulus(1'b1, F3_W, 32'h8, 32'h1234_FF80, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    applyStimulus(1'b0, F3_H, 32'h8, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lh", g_rd, 32'hFFFF_FF80);
    applyStimulus(1'b0, F3_HU, 32'hA, 32'h0, 5, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lhu", g_rd, 32'h0000_1234);
    applyStimulus(1'b0, F3_W, 32'h8, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lw", g_rd, 32'h1234_FF80);
    applyStimulus(1'b0, F3_B, 32'h9, 32'h0, 1, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lb", g_rd, 32'hFFFF_FFFF);

    applyStimulus(1'b0, F3_W, 32'hA, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lw_mis_fault", 32'(g_flt), 32'd1);
    checkOutput("lit_lw_mis_rdata", g_rd, 32'd0);
    applyStimulus(1'b0, 3'b011, 32'h0, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_f3_011_fault", 32'(g_flt), 32'd1);
    applyStimulus(1'b1, F3_BU, 32'h4, 32'hFFFF_FFFF, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    applyStimulus(1'b1, F3_H, 32'h1, 32'hFFFF_FFFF, 0, g_rd, g_flt, g_be, g_wd, g_addr);

    applyStimulus(1'b1, F3_H, 32'h6, 32'hAAAA_BEEF, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_sh_be", 32'(g_be), 32'hC);
    checkOutput("lit_sh_wdata", g_wd, 32'hBEEF_BEEF);
    applyStimulus(1'b0, F3_BU, 32'h7, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lbu", g_rd, 32'h0000_00BE);
    applyStimulus(1'b0, F3_W, 32'h4, 32'h0, 2, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lw4", g_rd, 32'hBEEF_7800);

    use3 = 1'b1;
    applyStimulus(1'b0, F3_W, 32'h8, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lw_wait3", g_rd, 32'h1234_FF80);
    applyStimulus(1'b1, F3_B, 32'hB, 32'h0000_00A5, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    applyStimulus(1'b0, F3_B, 32'hB, 32'h0, 0, g_rd, g_flt, g_be, g_wd, g_addr);
    checkOutput("lit_lb_wait3", g_rd, 32'hFFFF_FFA5);

    // Reset pulse in the middle of a multi-cycle read abandons the access.
    chk_en    = 1'b0;
    drv_valid = 1'b1;
    drv_store = 1'b0;
    drv_f3    = F3_W;
    drv_addr  = 32'h8;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_rst_read_strobe", 32'(s_rv), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("mid_rst_read_strobe", 32'(s_rv), 32'd0);
    checkOutput("mid_rst_write_strobe", 32'(s_wv), 32'd0);
    checkOutput("mid_rst_req_ready", 32'(s_req_ready), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_rst_resp_valid", 32'(s_resp_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
